// File: rtl/cfi_log_queue_pkg.sv
// Shared types for the CFI commit filter slice.
// Holds the subset of the ariane_pkg commit/CFI types this block needs
// (scoreboard entry, rule, log record) and the parameter limits used by the
// elaboration checks in cfi_log_queue.
package cfi_log_queue_pkg;

  localparam int unsigned CFI_MAX_RULES        = 16;
  localparam int unsigned CFI_MAX_COMMIT_PORTS = 4;

  localparam int unsigned VLEN = 64;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [VLEN-1:0]    pc;
    logic [ILEN-1:0]    instr;
    logic [XLEN-1:0]    result;
    branchpredict_sbe_t bp;
  } scoreboard_entry_t;

  typedef struct packed {
    logic            en;
    logic [ILEN-1:0] mask;
    logic [ILEN-1:0] pred;
  } cfi_rule_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [VLEN-1:0] addr_pc;
    logic [VLEN-1:0] addr_npc;
    logic [VLEN-1:0] addr_target;
  } cfi_log_t;

  function automatic logic rule_match(input logic [ILEN-1:0] instr,
                                      input cfi_rule_t       rule);
    return rule.en & ((instr & rule.mask) == rule.pred);
  endfunction

endpackage

// File: rtl/cfi_rule_match.sv
// Combinational rule matcher for one commit port.
// Ports:
//   sbe_i   - committing scoreboard entry
//   ack_i   - commit strobe for this port
//   rules_i - rule set {en, mask, pred}
//   excl_i  - per rule: 1 = exclude, 0 = include
//   hit_o   - entry is to be logged (include hit, no exclude hit, acked)
//   log_o   - log record built from the entry
module cfi_rule_match
  import cfi_log_queue_pkg::*;
#(
  parameter int unsigned NR_CFI_RULES = 4
) (
  input  scoreboard_entry_t                  sbe_i,
  input  logic                               ack_i,
  input  cfi_rule_t [NR_CFI_RULES-1:0]       rules_i,
  input  logic      [NR_CFI_RULES-1:0]       excl_i,
  output logic                               hit_o,
  output cfi_log_t                           log_o
);

  logic inc;
  logic exc;

  always_comb begin
    inc = 1'b0;
    exc = 1'b0;
    for (int unsigned j = 0; j < NR_CFI_RULES; j++) begin
      if (rule_match(sbe_i.instr, rules_i[j])) begin
        if (excl_i[j]) exc = 1'b1;
        else           inc = 1'b1;
      end
    end
    hit_o = ack_i & inc & ~exc;
  end

  always_comb begin
    log_o.instr       = sbe_i.instr;
    log_o.addr_pc     = sbe_i.pc;
    log_o.addr_npc    = sbe_i.result;
    log_o.addr_target = sbe_i.bp.predict_address;
  end

endmodule

// File: rtl/cfi_log_queue.sv
// CFI commit filter: matches every commit port against the rule set,
// registers the hits, and packs them in port order into a multi-push FIFO
// drained one log per cycle. Overflow drops are counted, never stalled.
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   flush_i             - discard stage register and FIFO contents
//   clr_stats_i         - clear drop_cnt_o / overflow_o
//   commit_sbe_i/ack_i  - committing entries and per-port strobes
//   cfi_rules_i/excl_i  - rule set and include/exclude selector
//   log_o/valid/ready   - FIFO head, valid/ready handshake
//   usage_o             - occupancy
//   drop_cnt_o          - saturating count of dropped logs
//   overflow_o          - sticky drop flag
module cfi_log_queue
  import cfi_log_queue_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_CFI_RULES    = 4,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DROP_CNT_W      = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic                                      clr_stats_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_sbe_i,
  input  logic              [NR_COMMIT_PORTS-1:0]   commit_ack_i,
  input  cfi_rule_t         [NR_CFI_RULES-1:0]      cfi_rules_i,
  input  logic              [NR_CFI_RULES-1:0]      cfi_excl_i,
  output cfi_log_t                                  log_o,
  output logic                                      log_valid_o,
  input  logic                                      log_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]           usage_o,
  output logic [DROP_CNT_W-1:0]                     drop_cnt_o,
  output logic                                      overflow_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH+1);
  localparam int unsigned DSUM_W = DROP_CNT_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < NR_COMMIT_PORTS)) begin : g_bad_depth
    $error("cfi_log_queue: FIFO_DEPTH must be a power of two and >= NR_COMMIT_PORTS");
  end
  if ((NR_COMMIT_PORTS < 1) || (NR_COMMIT_PORTS > CFI_MAX_COMMIT_PORTS)) begin : g_bad_ports
    $error("cfi_log_queue: NR_COMMIT_PORTS out of range");
  end
  if ((NR_CFI_RULES < 1) || (NR_CFI_RULES > CFI_MAX_RULES)) begin : g_bad_rules
    $error("cfi_log_queue: NR_CFI_RULES out of range");
  end

  logic     [NR_COMMIT_PORTS-1:0] hit;
  cfi_log_t [NR_COMMIT_PORTS-1:0] port_log;

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_match
    cfi_rule_match #(
      .NR_CFI_RULES (NR_CFI_RULES)
    ) i_match (
      .sbe_i   (commit_sbe_i[i]),
      .ack_i   (commit_ack_i[i]),
      .rules_i (cfi_rules_i),
      .excl_i  (cfi_excl_i),
      .hit_o   (hit[i]),
      .log_o   (port_log[i])
    );
  end

  logic     [NR_COMMIT_PORTS-1:0] stage_hit_q;
  cfi_log_t [NR_COMMIT_PORTS-1:0] stage_log_q;

  cfi_log_t mem_q [FIFO_DEPTH];
  ptr_t     wr_ptr_q, rd_ptr_q;
  cnt_t     usage_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  overflow_q;

  cnt_t free_cnt, push_cnt, drop_num;
  logic [NR_COMMIT_PORTS-1:0] slot_we;
  ptr_t slot_idx [NR_COMMIT_PORTS];
  logic pop;
  logic [DSUM_W-1:0] drop_sum;

  // Credit is the free space at the start of the cycle only; walking ports in
  // ascending order means the surviving hits are always the lowest ports.
  always_comb begin
    free_cnt = cnt_t'(FIFO_DEPTH) - usage_q;
    push_cnt = '0;
    drop_num = '0;
    slot_we  = '0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      slot_idx[i] = wr_ptr_q + push_cnt[PTR_W-1:0];
      if (stage_hit_q[i] && !flush_i) begin
        if (push_cnt < free_cnt) begin
          slot_we[i] = 1'b1;
          push_cnt   = push_cnt + cnt_t'(1);
        end else begin
          drop_num   = drop_num + cnt_t'(1);
        end
      end
    end
    pop      = log_valid_o & log_ready_i & ~flush_i;
    drop_sum = {1'b0, drop_cnt_q} + DSUM_W'(drop_num);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_hit_q <= '0;
      stage_log_q <= '0;
    end else begin
      stage_hit_q <= flush_i ? '0 : hit;
      stage_log_q <= port_log;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (slot_we[i]) mem_q[slot_idx[i]] <= stage_log_q[i];
      end
      wr_ptr_q <= wr_ptr_q + push_cnt[PTR_W-1:0];
      rd_ptr_q <= rd_ptr_q + ptr_t'(pop);
      usage_q  <= usage_q + push_cnt - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (clr_stats_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop_num != '0) begin
      drop_cnt_q <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      overflow_q <= 1'b1;
    end
  end

  assign log_valid_o = (usage_q != '0);
  assign log_o       = mem_q[rd_ptr_q];
  assign usage_o     = usage_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cfi_log_queue.sv
module tb_cfi_log_queue;
  import cfi_log_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, clr;
  scoreboard_entry_t [1:0] sbe;
  logic [1:0] ack;
  cfi_rule_t [3:0] rules;
  logic [3:0] excl;
  cfi_log_t log;
  logic log_valid, ready;
  logic [3:0] usage;
  logic [15:0] drop;
  logic ovf;

  int checks = 0;
  int failures = 0;

  cfi_log_queue #(
    .NR_COMMIT_PORTS (2),
    .NR_CFI_RULES    (4),
    .FIFO_DEPTH      (8),
    .DROP_CNT_W      (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .clr_stats_i  (clr),
    .commit_sbe_i (sbe),
    .commit_ack_i (ack),
    .cfi_rules_i  (rules),
    .cfi_excl_i   (excl),
    .log_o        (log),
    .log_valid_o  (log_valid),
    .log_ready_i  (ready),
    .usage_o      (usage),
    .drop_cnt_o   (drop),
    .overflow_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input int p, input logic [31:0] instr, input logic [63:0] pc);
    sbe[p].instr              = instr;
    sbe[p].pc                 = pc;
    sbe[p].result             = pc + 64'h4;
    sbe[p].bp.predict_address = pc + 64'h100;
    ack[p]                    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; clr = 0; ack = '0; ready = 0;
    sbe = '0; rules = '0; excl = '0;
    step(); step();
    checks++; if (log_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", log_valid); end
    checks++; if (usage !== 4'd0) begin failures++; $display("FAIL rst_usage got=%0d exp=0", usage); end
    checks++; if (drop !== 16'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
    checks++; if (log !== '0) begin failures++; $display("FAIL rst_log got=%h exp=0", log); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_jal();
    rules[0] = '{en: 1'b1, mask: 32'h7F, pred: 32'h6F};
    commit(0, 32'h008000EF, 64'h8000_0000);
    step();
    ack = '0;
    checks++; if (log_valid !== 1'b0) begin failures++; $display("FAIL jal_t1_valid got=%0b exp=0", log_valid); end
    step();
    checks++; if (log_valid !== 1'b1) begin failures++; $display("FAIL jal_valid got=%0b exp=1", log_valid); end
    checks++; if (log.addr_pc !== 64'h8000_0000) begin failures++; $display("FAIL jal_pc got=%h exp=80000000", log.addr_pc); end
    checks++; if (log.instr !== 32'h008000EF) begin failures++; $display("FAIL jal_instr got=%h exp=008000ef", log.instr); end
    checks++; if (log.addr_npc !== 64'h8000_0004) begin failures++; $display("FAIL jal_npc got=%h exp=80000004", log.addr_npc); end
    checks++; if (log.addr_target !== 64'h8000_0100) begin failures++; $display("FAIL jal_tgt got=%h exp=80000100", log.addr_target); end
    checks++; if (usage !== 4'd1) begin failures++; $display("FAIL jal_usage got=%0d exp=1", usage); end
    ready = 1; step(); ready = 0;
    checks++; if (usage !== 4'd0) begin failures++; $display("FAIL jal_pop_usage got=%0d exp=0", usage); end
  endtask

  task automatic test_exclude();
    rules[1] = '{en: 1'b1, mask: 32'hFFF, pred: 32'h0EF};
    excl[1]  = 1'b1;
    commit(0, 32'h008000EF, 64'h8000_0010);
    step(); ack = '0; step(); step();
    checks++; if (usage !== 4'd0) begin failures++; $display("FAIL excl_usage got=%0d exp=0", usage); end
    checks++; if (log_valid !== 1'b0) begin failures++; $display("FAIL excl_valid got=%0b exp=0", log_valid); end
    // rd=x0 passes the exclude rule
    commit(1, 32'h0080006F, 64'h8000_0020);
    step(); ack = '0; step();
    checks++; if (log_valid !== 1'b1 || log.instr !== 32'h0080006F) begin failures++; $display("FAIL excl_x0 got=%0b/%h exp=1/0080006f", log_valid, log.instr); end
    ready = 1; step(); ready = 0;
    rules[1].en = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      commit(0, 32'h0000006F, 64'h100 + 64'(i));
      commit(1, 32'h0000006F, 64'h200 + 64'(i));
      step();
    end
    checks++; if (usage !== 4'd8) begin failures++; $display("FAIL ovf_usage got=%0d exp=8", usage); end
    checks++; if (drop !== 16'd2) begin failures++; $display("FAIL ovf_drop1 got=%0d exp=2", drop); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
    ack = '0; step();
    checks++; if (drop !== 16'd4) begin failures++; $display("FAIL ovf_drop2 got=%0d exp=4", drop); end
    clr = 1; step(); clr = 0;
    checks++; if (drop !== 16'd0 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0d/%0b exp=0/0", drop, ovf); end
    checks++; if (usage !== 4'd8) begin failures++; $display("FAIL ovf_clr_usage got=%0d exp=8", usage); end
    flush = 1; step(); flush = 0;
    checks++; if (usage !== 4'd0) begin failures++; $display("FAIL ovf_flush got=%0d exp=0", usage); end
  endtask

  task automatic test_usage7_pop();
    logic [63:0] exp_pc;
    for (int i = 0; i < 7; i++) begin
      ack = '0;
      commit(0, 32'h0000006F, 64'h1000 + 64'(4 * i));
      step();
    end
    commit(0, 32'h0000006F, 64'h2000);
    commit(1, 32'h0000006F, 64'h3000);
    step();
    ack = '0;
    checks++; if (usage !== 4'd7) begin failures++; $display("FAIL u7_pre got=%0d exp=7", usage); end
    ready = 1; step(); ready = 0;
    checks++; if (usage !== 4'd7) begin failures++; $display("FAIL u7_usage got=%0d exp=7", usage); end
    checks++; if (drop !== 16'd1 || ovf !== 1'b1) begin failures++; $display("FAIL u7_drop got=%0d/%0b exp=1/1", drop, ovf); end
    ready = 1;
    for (int k = 0; k < 7; k++) begin
      exp_pc = (k < 6) ? 64'h1004 + 64'(4 * k) : 64'h2000;
      checks++; if (log_valid !== 1'b1 || log.addr_pc !== exp_pc) begin failures++; $display("FAIL u7_order%0d got=%0b/%h exp=1/%h", k, log_valid, log.addr_pc, exp_pc); end
      step();
    end
    ready = 0;
    checks++; if (log_valid !== 1'b0) begin failures++; $display("FAIL u7_empty got=%0b exp=0", log_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      commit(0, 32'h0000006F, 64'h5000 + 64'(4 * i));
      step();
    end
    commit(0, 32'h0000006F, 64'h5100);
    step();
    ack = '0;
    checks++; if (usage !== 4'd5) begin failures++; $display("FAIL fl_pre got=%0d exp=5", usage); end
    flush = 1; step(); flush = 0;
    checks++; if (usage !== 4'd0 || log_valid !== 1'b0) begin failures++; $display("FAIL fl_clear got=%0d/%0b exp=0/0", usage, log_valid); end
    checks++; if (drop !== 16'd1 || ovf !== 1'b1) begin failures++; $display("FAIL fl_stats got=%0d/%0b exp=1/1", drop, ovf); end
    step();
    checks++; if (usage !== 4'd0) begin failures++; $display("FAIL fl_stage got=%0d exp=0", usage); end
  endtask

  task automatic test_random_ready();
    int sent = 0;
    int recv = 0;
    logic [63:0] exp_pc;
    clr = 1; step(); clr = 0;
    for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
      ack = '0;
      if (sent < 20) begin
        commit(sent % 2, 32'h0000006F, 64'h4000 + 64'(4 * sent));
        sent++;
      end
      ready = (usage >= 4'd5) ? 1'b1 : 1'($urandom_range(0, 1));
      if (log_valid && ready) begin
        exp_pc = 64'h4000 + 64'(4 * recv);
        checks++; if (log.addr_pc !== exp_pc) begin failures++; $display("FAIL rnd_order%0d got=%h exp=%h", recv, log.addr_pc, exp_pc); end
        recv++;
      end
      step();
    end
    ack = '0; ready = 0;
    checks++; if (recv != 20) begin failures++; $display("FAIL rnd_count got=%0d exp=20", recv); end
    checks++; if (drop !== 16'd0 || ovf !== 1'b0) begin failures++; $display("FAIL rnd_loss got=%0d/%0b exp=0/0", drop, ovf); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      commit(0, 32'h0000006F, 64'h6000 + 64'(4 * i));
      step();
    end
    ack = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (usage !== 4'd0 || log_valid !== 1'b0) begin failures++; $display("FAIL mrst_async got=%0d/%0b exp=0/0", usage, log_valid); end
    step();
    rst_n = 1'b1;
    step(); step(); step();
    checks++; if (usage !== 4'd0 || log_valid !== 1'b0) begin failures++; $display("FAIL mrst_after got=%0d/%0b exp=0/0", usage, log_valid); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_exclude();
    test_overflow();
    test_usage7_pop();
    test_flush();
    test_random_ready();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfi_log_queue.md
# cfi_log_queue

Second-generation CFI commit filter: every cycle it matches each committed instruction on every CVA6 commit port against a parametrised set of include/exclude rules. Hits are registered, then packed in port order into a multi-push FIFO. The FIFO drains one `cfi_log_t` per cycle over a valid/ready interface toward the CFI monitor. Overflow drops are counted, not stalled, because commit cannot be back-pressured.

## Interface
- `NR_COMMIT_PORTS`, 2, commit ports observed (1..4).
- `NR_CFI_RULES`, 4, rule slots (1..16).
- `FIFO_DEPTH`, 8, log entries; power of two, ≥ `NR_COMMIT_PORTS`.
- `DROP_CNT_W`, 16, drop counter width.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  discard all pending logs (stage register and FIFO).
- `clr_stats_i`  in  1  clear `drop_cnt_o` and `overflow_o`.
- `commit_sbe_i`  in  `scoreboard_entry_t[NR_COMMIT_PORTS]`  committing entries.
- `commit_ack_i`  in  `NR_COMMIT_PORTS`  per-port commit strobe.
- `cfi_rules_i`  in  `cfi_rule_t[NR_CFI_RULES]`  {en, mask, pred} per rule.
- `cfi_excl_i`  in  `NR_CFI_RULES`  1 = rule is an exclude rule, 0 = include rule.
- `log_o`  out  `cfi_log_t`  FIFO head {instr, addr_pc, addr_npc, addr_target}.
- `log_valid_o`  out  1  head valid.
- `log_ready_i`  in  1  consumer accepts head.
- `usage_o`  out  `$clog2(FIFO_DEPTH+1)`  current occupancy.
- `drop_cnt_o`  out  `DROP_CNT_W`  logs lost to overflow; saturating.
- `overflow_o`  out  1  sticky; set on first drop.

## Operation
- Match per port `i`, rule `j`: `m[i][j] = ((instr & mask) == pred) & en`.
- `inc[i]` = OR of `m[i][j]` over include rules. `exc[i]` = OR over exclude rules.
- `hit[i] = commit_ack_i[i] & inc[i] & ~exc[i]`. Exclude overrides include. With no enabled include rule nothing is logged.
- Log fields: `instr`←`instr`, `addr_pc`←`pc`, `addr_npc`←`result`, `addr_target`←`bp.predict_address`.
- Stage register: `hit` vector and all port logs captured every cycle. Stage valid bits reset to 0.
- Enqueue: stage hits are written in ascending port order at consecutive write-pointer slots in one cycle.
- Free space = `FIFO_DEPTH − usage` at the start of the cycle. A same-cycle pop grants no credit.
- Hits beyond the free space are dropped, always the highest-numbered ports. `drop_cnt_o` += dropped count, saturating at all-ones. `overflow_o` ← 1.
- Dequeue: `log_valid_o = (usage != 0)`. Pop when `log_valid_o & log_ready_i`. `log_o` is the entry at the read pointer. `log_o` is don't-care while invalid, but must not be X after reset.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. `usage` updates as += pushes − pop in the same cycle.
- `flush_i`: clears stage valid bits, both pointers and usage. Same-cycle push and pop are suppressed. Statistics are not affected.
- `clr_stats_i`: zeroes `drop_cnt_o` and `overflow_o`. If a drop occurs in the same cycle, clear wins and that drop is not counted.
- Rules are sampled combinationally in the commit cycle. A rule change affects the next commit only.

## Timing
- Reset values: `log_valid_o`=0, `usage_o`=0, `drop_cnt_o`=0, `overflow_o`=0, `log_o`=0, pointers 0.
- Latency: commit with hit in cycle t → stage valid in t+1 → `log_valid_o`=1 in t+2 (empty FIFO).
- Throughput: up to `NR_COMMIT_PORTS` pushes and 1 pop per cycle.
- A dropped entry updates `drop_cnt_o` and `overflow_o` at the same edge the surviving entries are written, visible in t+2.
- `log_o` holds stable while `log_valid_o & ~log_ready_i`.
- `rst_ni` asserted mid-operation: all state clears asynchronously. No log is emitted after deassertion until new commits arrive.

## Structure
- `cfi_rule_t`, `cfi_log_t` stay in `ariane_pkg`. Add `CFI_MAX_RULES`=16 and `CFI_MAX_COMMIT_PORTS`=4 there for parameter checks.
- Sub-module `cfi_rule_match` (combinational): one commit entry plus the rule set → `hit`, `cfi_log_t`. Instantiate it `NR_COMMIT_PORTS` times.
- FIFO is custom, in-module. A single-push common FIFO does not fit the multi-push requirement.
- Elaboration assertions: `FIFO_DEPTH` is a power of two and ≥ `NR_COMMIT_PORTS`.

## Test plan
- Rule0 include, mask `0x7F`, pred `0x6F` (JAL). Port0 commits `0x008000EF` at t, pc `0x80000000` → `log_valid_o` at t+2 with `addr_pc`=`0x80000000`, `usage_o`=1.
- Rule0 include JAL, rule1 exclude mask `0xFFF`, pred `0x0EF` (rd=ra). JAL x1 commit → no log, `usage_o` stays 0.
- Both ports hit every cycle, `log_ready_i`=0, depth 8 → full after 4 pushes, then `drop_cnt_o` += 2/cycle, `overflow_o`=1. `clr_stats_i` → both 0 next cycle.
- Usage 7, two hits, pop same cycle → port0 enqueued, port1 dropped, `drop_cnt_o`=1, `usage_o`=7.
- 20 single hits with random `log_ready_i` → output order equals commit order, pointers wrap, no loss.
- `flush_i` with 5 queued and a hit in the stage register → next cycle `usage_o`=0, `log_valid_o`=0, statistics unchanged.
